// File: rtl/ccip_avmm_mmio_arbiter_if.sv
// rtl/ccip_avmm_mmio_arbiter_if.sv - AVMM MMIO port bundle shared by the arbiter's upstream and downstream sides
//
// Purpose: one AVMM command/response port.
//   master modport: drives address/writedata/byteenable/write/read,
//                   receives waitrequest/readdata/readdatavalid.
//   slave modport : the mirror image.
// Ports (signals):
//   address     ADDR_WIDTH      byte address
//   writedata   DATA_WIDTH      write data
//   byteenable  DATA_WIDTH/8    byte enables
//   write/read  1               command strobes
//   waitrequest 1               command stall; command accepted when 0
//   readdata    DATA_WIDTH      read response data
//   readdatavalid 1             read response valid
interface ccip_avmm_mmio_arbiter_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    write;
  logic                    read;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, writedata, byteenable, write, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, writedata, byteenable, write, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/ccip_avmm_mmio_arbiter.sv
// rtl/ccip_avmm_mmio_arbiter.sv - two-port round-robin AVMM MMIO arbiter with in-order read response routing
//
// Purpose: shares one downstream AVMM MMIO master between port 0 (CCI-P MMIO
// bridge) and port 1 (local AFU config/debug master). A registered command
// stage (CMD) drives the downstream port; a FIFO of issuing-port ids routes
// each in-order read response back to the port that issued the read.
// Ports:
//   clk                 clock, all logic on posedge
//   reset               synchronous, active-low
//   s0, s1              upstream AVMM slave ports
//   m                   downstream AVMM master port
//   pending_reads       downstream reads accepted and not yet answered
//   err_unexpected_rsp  sticky: readdatavalid seen with no read outstanding
module ccip_avmm_mmio_arbiter #(
  parameter int ADDR_WIDTH        = 18,
  parameter int DATA_WIDTH        = 64,
  parameter int MAX_PENDING_READS = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  ccip_avmm_mmio_arbiter_if.slave             s0,
  ccip_avmm_mmio_arbiter_if.slave             s1,
  ccip_avmm_mmio_arbiter_if.master            m,
  output logic [$clog2(MAX_PENDING_READS):0]  pending_reads,
  output logic                                err_unexpected_rsp
);

  localparam int PTR_W = $clog2(MAX_PENDING_READS);
  localparam int CNT_W = PTR_W + 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  typedef enum logic {CMD_EMPTY, CMD_FULL} cmd_state_t;

  cmd_state_t cmd_state, cmd_state_nxt;

  logic                  cmd_read, cmd_write, cmd_port;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [BE_W-1:0]       cmd_be;
  logic                  last_grant;

  logic                  cmd_can_load, cmd_retire, cmd_hold_read;
  logic [CNT_W:0]        reads_committed;
  logic                  read_room;
  logic                  s0_elig, s1_elig;
  logic                  grant_valid, grant_port;

  logic                  sel_read, sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BE_W-1:0]       sel_be;

  logic                  fifo_mem [MAX_PENDING_READS];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  push, pop, unexpected;

  logic                  rsp_valid, rsp_port;
  logic [DATA_WIDTH-1:0] rsp_data;

  // ---------------------------------------------------------------- arbitration
  assign cmd_retire    = (cmd_state == CMD_FULL) && !m.waitrequest;
  assign cmd_can_load  = (cmd_state == CMD_EMPTY) || !m.waitrequest;
  assign cmd_hold_read = (cmd_state == CMD_FULL) && cmd_read;

  // A read sitting in CMD counts against the limit even before it is accepted
  // downstream, so admission can never overrun the tracking FIFO.
  assign reads_committed = {1'b0, pending_reads} + (CNT_W+1)'(cmd_hold_read);
  assign read_room       = reads_committed < (CNT_W+1)'(MAX_PENDING_READS);

  // Read wins over write when a requester illegally raises both.
  assign s0_elig = s0.read ? read_room : s0.write;
  assign s1_elig = s1.read ? read_room : s1.write;

  always_comb begin
    grant_valid   = 1'b0;
    grant_port    = 1'b0;
    cmd_state_nxt = cmd_state;
    if (cmd_can_load) begin
      if (s0_elig && s1_elig) begin
        grant_valid = 1'b1;
        grant_port  = ~last_grant;
      end else if (s0_elig) begin
        grant_valid = 1'b1;
        grant_port  = 1'b0;
      end else if (s1_elig) begin
        grant_valid = 1'b1;
        grant_port  = 1'b1;
      end
    end
    if (grant_valid) begin
      cmd_state_nxt = CMD_FULL;
    end else if (cmd_retire) begin
      cmd_state_nxt = CMD_EMPTY;
    end
  end

  assign s0.waitrequest = !(grant_valid && (grant_port == 1'b0));
  assign s1.waitrequest = !(grant_valid && (grant_port == 1'b1));

  assign sel_read  = grant_port ? s1.read       : s0.read;
  assign sel_write = grant_port ? s1.write      : s0.write;
  assign sel_addr  = grant_port ? s1.address    : s0.address;
  assign sel_wdata = grant_port ? s1.writedata  : s0.writedata;
  assign sel_be    = grant_port ? s1.byteenable : s0.byteenable;

  // ---------------------------------------------------------------- command stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_state  <= CMD_EMPTY;
      cmd_read   <= 1'b0;
      cmd_write  <= 1'b0;
      cmd_port   <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_be     <= '0;
      last_grant <= 1'b1;
    end else begin
      cmd_state <= cmd_state_nxt;
      if (grant_valid) begin
        cmd_read   <= sel_read;
        cmd_write  <= sel_write && !sel_read;
        cmd_port   <= grant_port;
        cmd_addr   <= sel_addr;
        cmd_wdata  <= sel_wdata;
        cmd_be     <= sel_be;
        last_grant <= grant_port;
      end
    end
  end

  // Downstream outputs come straight from registers; m.waitrequest never
  // reaches them combinationally.
  assign m.read       = (cmd_state == CMD_FULL) && cmd_read;
  assign m.write      = (cmd_state == CMD_FULL) && cmd_write;
  assign m.address    = cmd_addr;
  assign m.writedata  = cmd_wdata;
  assign m.byteenable = cmd_be;

  // ---------------------------------------------------------------- read tracking
  assign push       = m.read && !m.waitrequest;
  assign pop        = m.readdatavalid && (pending_reads != '0);
  assign unexpected = m.readdatavalid && (pending_reads == '0);

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= cmd_port;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      pending_reads      <= '0;
      err_unexpected_rsp <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_port           <= 1'b0;
      rsp_data           <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   pending_reads <= pending_reads + CNT_W'(1);
        2'b01:   pending_reads <= pending_reads - CNT_W'(1);
        default: pending_reads <= pending_reads;
      endcase
      if (unexpected) begin
        err_unexpected_rsp <= 1'b1;
      end
      rsp_valid <= pop;
      if (pop) begin
        rsp_port <= fifo_mem[rd_ptr];
        rsp_data <= m.readdata;
      end
    end
  end

  assign s0.readdata      = rsp_data;
  assign s1.readdata      = rsp_data;
  assign s0.readdatavalid = rsp_valid && (rsp_port == 1'b0);
  assign s1.readdatavalid = rsp_valid && (rsp_port == 1'b1);

endmodule

// File: tb/tb_ccip_avmm_mmio_arbiter.sv
// tb/tb_ccip_avmm_mmio_arbiter.sv - directed self-checking bench for ccip_avmm_mmio_arbiter
module tb_ccip_avmm_mmio_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] pending_reads;
  logic       err_unexpected_rsp;

  int n_checks = 0;
  int n_errors = 0;

  // Downstream responder controls, written by the stimulus thread.
  int auto_rsp   = 0;
  int manual_rsp = 0;

  logic        acc;
  logic [17:0] acc_addr;
  logic        p1_v;
  logic [63:0] p1_d;

  int          q_port [$];
  logic [63:0] q_data [$];

  int grants;

  always #5 clk = ~clk;

  ccip_avmm_mmio_arbiter_if #(.ADDR_WIDTH(18), .DATA_WIDTH(64)) s0_if ();
  ccip_avmm_mmio_arbiter_if #(.ADDR_WIDTH(18), .DATA_WIDTH(64)) s1_if ();
  ccip_avmm_mmio_arbiter_if #(.ADDR_WIDTH(18), .DATA_WIDTH(64)) m_if ();

  ccip_avmm_mmio_arbiter #(
    .ADDR_WIDTH(18),
    .DATA_WIDTH(64),
    .MAX_PENDING_READS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s0(s0_if),
    .s1(s1_if),
    .m(m_if),
    .pending_reads(pending_reads),
    .err_unexpected_rsp(err_unexpected_rsp)
  );

  function automatic logic [63:0] rsp_data(input logic [17:0] a);
    return 64'hA5A5_0000_0000_0000 | {46'd0, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    s0_if.read = 0; s0_if.write = 0; s0_if.address = '0; s0_if.writedata = '0; s0_if.byteenable = '0;
    s1_if.read = 0; s1_if.write = 0; s1_if.address = '0; s1_if.writedata = '0; s1_if.byteenable = '0;
    m_if.waitrequest = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_inputs();
    auto_rsp = 0;
    manual_rsp = 0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1;
    q_port.delete();
    q_data.delete();
  endtask

  // Downstream model: in auto mode each accepted read is answered two cycles
  // after its accept cycle; in manual mode one fixed-data pulse per request.
  initial begin
    m_if.readdatavalid = 0;
    m_if.readdata = '0;
    p1_v = 0;
    p1_d = '0;
    forever begin
      @(negedge clk);
      acc = m_if.read && !m_if.waitrequest;
      acc_addr = m_if.address;
      @(posedge clk);
      #1;
      if (auto_rsp != 0) begin
        m_if.readdatavalid = p1_v;
        m_if.readdata = p1_d;
      end else if (manual_rsp > 0) begin
        m_if.readdatavalid = 1;
        m_if.readdata = 64'h1234_5678_9ABC_DEF0;
        manual_rsp--;
      end else begin
        m_if.readdatavalid = 0;
      end
      p1_v = acc && (auto_rsp != 0);
      p1_d = rsp_data(acc_addr);
    end
  end

  always @(negedge clk) begin
    if (s0_if.readdatavalid) begin
      q_port.push_back(0);
      q_data.push_back(s0_if.readdata);
    end
    if (s1_if.readdatavalid) begin
      q_port.push_back(1);
      q_data.push_back(s1_if.readdata);
    end
  end

  initial begin
    do_reset();

    // Reset state
    check("rst_m_read", m_if.read, 0);
    check("rst_m_write", m_if.write, 0);
    check("rst_s0_wait", s0_if.waitrequest, 1);
    check("rst_s1_wait", s1_if.waitrequest, 1);
    check("rst_pending", pending_reads, 0);
    check("rst_err", err_unexpected_rsp, 0);

    // Single port 0 write
    s0_if.write = 1; s0_if.address = 18'h0040;
    s0_if.writedata = 64'hDEADBEEF_CAFEF00D; s0_if.byteenable = 8'hFF;
    #1;
    check("wr_s0_wait", s0_if.waitrequest, 0);
    check("wr_s1_wait", s1_if.waitrequest, 1);
    step();
    s0_if.write = 0;
    #1;
    check("wr_m_write", m_if.write, 1);
    check("wr_m_read", m_if.read, 0);
    check("wr_m_addr", m_if.address, 18'h0040);
    check("wr_m_data", m_if.writedata, 64'hDEADBEEF_CAFEF00D);
    check("wr_m_be", m_if.byteenable, 8'hFF);
    check("wr_s0_wait_idle", s0_if.waitrequest, 1);
    step();
    check("wr_m_write_done", m_if.write, 0);
    repeat (3) step();
    check("wr_no_rsp", q_port.size(), 0);

    // Both ports reading continuously: strict alternation, correct routing
    do_reset();
    auto_rsp = 1;
    s0_if.read = 1; s0_if.address = 18'h10;
    s1_if.read = 1; s1_if.address = 18'h20;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr_s0_wait_%0d", i), s0_if.waitrequest, (i % 2 == 1));
      check($sformatf("rr_s1_wait_%0d", i), s1_if.waitrequest, (i % 2 == 0));
      step();
    end
    s0_if.read = 0; s1_if.read = 0;
    repeat (8) step();
    check("rr_rsp_count", q_port.size(), 8);
    for (int k = 0; k < 8 && k < q_port.size(); k++) begin
      check($sformatf("rr_port_%0d", k), q_port[k], k % 2);
      check($sformatf("rr_data_%0d", k), q_data[k], rsp_data((k % 2 == 1) ? 18'h20 : 18'h10));
    end
    check("rr_pending_drained", pending_reads, 0);

    // Downstream stall during a port 1 read
    do_reset();
    s1_if.read = 1; s1_if.address = 18'h88;
    #1;
    check("st_s1_grant", s1_if.waitrequest, 0);
    step();
    s1_if.read = 0;
    m_if.waitrequest = 1;
    s0_if.write = 1; s0_if.address = 18'h44; s0_if.writedata = 64'h1111; s0_if.byteenable = 8'h0F;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("st_m_read_%0d", k), m_if.read, 1);
      check($sformatf("st_m_addr_%0d", k), m_if.address, 18'h88);
      check($sformatf("st_s0_wait_%0d", k), s0_if.waitrequest, 1);
      check($sformatf("st_s1_wait_%0d", k), s1_if.waitrequest, 1);
      check($sformatf("st_pending_%0d", k), pending_reads, 0);
      step();
    end
    m_if.waitrequest = 0;
    #1;
    check("st_s0_grant_on_release", s0_if.waitrequest, 0);
    step();
    s0_if.write = 0;
    #1;
    check("st_pending_one", pending_reads, 1);
    check("st_m_write", m_if.write, 1);
    check("st_m_read_gone", m_if.read, 0);
    check("st_m_addr_wr", m_if.address, 18'h44);
    step();
    check("st_pending_still_one", pending_reads, 1);

    // Read admission limit (MAX_PENDING_READS = 4)
    do_reset();
    grants = 0;
    s0_if.read = 1; s0_if.address = 18'h100;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (!s0_if.waitrequest) grants++;
      step();
    end
    check("lim_grants", grants, 4);
    check("lim_pending", pending_reads, 4);
    #1;
    check("lim_s0_blocked", s0_if.waitrequest, 1);
    s1_if.write = 1; s1_if.address = 18'h200; s1_if.writedata = 64'h2222; s1_if.byteenable = 8'hFF;
    #1;
    check("lim_s1_write_grant", s1_if.waitrequest, 0);
    check("lim_s0_still_blocked", s0_if.waitrequest, 1);
    step();
    s1_if.write = 0;
    #1;
    check("lim_m_write", m_if.write, 1);
    check("lim_m_addr", m_if.address, 18'h200);
    manual_rsp = 1;
    step();
    check("lim_pending_before_pop", pending_reads, 4);
    step();
    check("lim_pending_after_pop", pending_reads, 3);
    #1;
    check("lim_s0_readmitted", s0_if.waitrequest, 0);
    s0_if.read = 0;
    step();
    check("lim_rsp_count", q_port.size(), 1);
    if (q_port.size() > 0) begin
      check("lim_rsp_port", q_port[0], 0);
      check("lim_rsp_data", q_data[0], 64'h1234_5678_9ABC_DEF0);
    end

    // Unexpected response
    do_reset();
    check("ux_err_clear", err_unexpected_rsp, 0);
    manual_rsp = 1;
    step();
    step();
    check("ux_err_set", err_unexpected_rsp, 1);
    repeat (3) step();
    check("ux_err_sticky", err_unexpected_rsp, 1);
    check("ux_no_rsp", q_port.size(), 0);
    check("ux_pending", pending_reads, 0);
    do_reset();
    check("ux_err_reset", err_unexpected_rsp, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ccip_avmm_mmio_arbiter.md
Name: ccip_avmm_mmio_arbiter

Overview:
- Shares one downstream AVMM MMIO master port between two upstream AVMM requesters: port 0 is the CCI-P MMIO bridge, port 1 is a local AFU config/debug master.
- Round-robin arbitration with a registered command stage.
- Tracks outstanding reads in order and routes each readdatavalid back to the port that issued the read.
- Sits between the CCI-P MMIO bridge and the AFU CSR interconnect.

Parameters:
- ADDR_WIDTH, 18, AVMM byte address width (all ports).
- DATA_WIDTH, 64, AVMM data width; byteenable width is DATA_WIDTH/8.
- MAX_PENDING_READS, 16, maximum downstream reads outstanding; power of 2, 2..64.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- sN_address  in  ADDR_WIDTH  port N (N=0,1) address.
- sN_writedata  in  DATA_WIDTH  port N write data.
- sN_byteenable  in  DATA_WIDTH/8  port N byte enables.
- sN_write  in  1  port N write request.
- sN_read  in  1  port N read request.
- sN_waitrequest  out  1  port N stall; the command is accepted in the cycle sN_waitrequest=0.
- sN_readdata  out  DATA_WIDTH  port N read data.
- sN_readdatavalid  out  1  port N read data valid.
- m_address  out  ADDR_WIDTH  downstream address.
- m_writedata  out  DATA_WIDTH  downstream write data.
- m_byteenable  out  DATA_WIDTH/8  downstream byte enables.
- m_write  out  1  downstream write.
- m_read  out  1  downstream read.
- m_waitrequest  in  1  downstream stall.
- m_readdata  in  DATA_WIDTH  downstream read data.
- m_readdatavalid  in  1  downstream read data valid.
- pending_reads  out  $clog2(MAX_PENDING_READS)+1  current outstanding read count.
- err_unexpected_rsp  out  1  sticky flag: m_readdatavalid arrived with no read outstanding.

Behaviour:
- Reset values (reset=0 at a clock edge): m_read=0, m_write=0, s0/s1_waitrequest=1, s0/s1_readdatavalid=0, pending_reads=0, err_unexpected_rsp=0, last_grant=1 (so port 0 wins first), tracking FIFO empty.
- Request: sN_req = sN_read|sN_write. Both asserted on the same port is illegal; read takes precedence.
- Command register (CMD) states:
  - EMPTY: m_read=m_write=0.
  - FULL: m_read or m_write = 1.
  - CMD can load when EMPTY, or when FULL and m_waitrequest=0 (the current command retires this cycle).
- Read admission:
  - eligibility = pending_reads + (CMD holds a read) < MAX_PENDING_READS.
  - A read request is ineligible while this is false. Writes are always eligible.
- Grant: among eligible requesters, if both are eligible grant the port != last_grant; otherwise grant the sole eligible port.
- On a grant, in the same cycle:
  - granted sN_waitrequest=0; the other port's waitrequest=1.
  - Next cycle, CMD holds the granted port's address/writedata/byteenable/read/write; last_grant updates.
  - Each accepted upstream command appears on m_* exactly one cycle later.
- If CMD cannot load, both waitrequests=1.
- m_* outputs stay stable while m_waitrequest=1.
- A downstream read is accepted when m_read=1 and m_waitrequest=0. That cycle:
  - the port id of the read is pushed into the tracking FIFO;
  - pending_reads increments, unless a pop occurs in the same cycle (push+pop = no change).
- m_readdatavalid=1:
  - Pops the FIFO head id. pending_reads decrements.
  - Next cycle: s[id]_readdatavalid=1, and s0_readdata/s1_readdata = registered m_readdata (one-cycle latency). The other port's readdatavalid stays 0.
  - Responses are strictly in order.
- m_readdatavalid with an empty FIFO:
  - Response dropped; no sN_readdatavalid.
  - err_unexpected_rsp set; cleared only by reset.
- Writes produce no response and no FIFO entry.
- Reset mid-operation:
  - CMD and FIFO cleared; in-flight commands discarded.
  - Late downstream responses after reset set err_unexpected_rsp.
- No combinational path from m_waitrequest to m_*.
- sN_waitrequest depends combinationally on sN_read/sN_write, m_waitrequest and CMD state.

Test Plan:
- Reset held 3 cycles, then released with no requests -> m_read=m_write=0; s0/s1_waitrequest=1; pending_reads=0; err_unexpected_rsp=0.
- Port 0 write (addr 0x0040, data 0xDEADBEEF_CAFEF00D, be 0xFF) with m_waitrequest=0 -> s0_waitrequest=0 for 1 cycle; next cycle m_write=1 with identical addr/data/be; no readdatavalid on either port.
- s0 and s1 both read continuously (addr 0x10, 0x20), m_waitrequest=0, downstream returns data 2 cycles after each read -> grants alternate s0,s1,s0,s1; each readdata routes to the issuing port in order; no cross-routing.
- m_waitrequest held 1 for 5 cycles during a port 1 read -> m_read/m_address stable all 5 cycles; both sN_waitrequest=1; exactly one FIFO push, on release.
- MAX_PENDING_READS=4, 6 reads from port 0, downstream withholds responses -> pending_reads saturates at 4; s0_waitrequest=1 for reads; a port 1 write is still granted; one response frees one slot.
- m_readdatavalid pulsed with pending_reads=0 -> no sN_readdatavalid; err_unexpected_rsp=1 and held until reset.
